// File: rtl/msu_pkg.sv
// Shared types and defaults for the modular squaring unit (MSU) blocks.
package msu_pkg;

    // Width of one operand vector (nr and r are each this wide).
    localparam int TotalWordBits = 16;

    // Defaults for the iteration sequencer.
    localparam int DefaultSqLatency          = 4;
    localparam int DefaultCheckpointInterval = 0;

    // Sequencer states: wait for a job, launch one squaring, wait for its
    // result, present a result beat.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        EMIT   = 2'd3
    } msu_seq_state_e;

endpackage

// File: rtl/msu_seq.sv
// Job-based iteration sequencer for the modular squaring datapath.
//
// Handshakes: a transfer happens on any rising clk_i edge where valid and
// ready are both high. in_ready_o is high only in IDLE. out_valid_o is high
// only in EMIT and every beat field is held stable until out_ready_i is seen.
//
// Each iteration launches the external pipeline for one cycle (LAUNCH), then
// waits SqLatency cycles (WAIT) and captures the result into the feedback
// registers, which drive dp_nr_o/dp_r_o continuously. Iteration period is
// therefore SqLatency+1 cycles, and a launch is never issued while another
// is in flight.
module msu_seq
    import msu_pkg::*;
#(
    parameter int DataBits           = TotalWordBits,
    parameter int IterBits           = 32,
    parameter int SqLatency          = DefaultSqLatency,
    parameter int CheckpointInterval = DefaultCheckpointInterval
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DataBits-1:0] in_nr_i,
    input  logic [DataBits-1:0] in_r_i,
    input  logic [IterBits-1:0] in_iter_i,
    input  logic                stop_i,
    output logic                dp_start_o,
    output logic [DataBits-1:0] dp_nr_o,
    output logic [DataBits-1:0] dp_r_o,
    input  logic [DataBits-1:0] dp_nr_i,
    input  logic [DataBits-1:0] dp_r_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DataBits-1:0] out_nr_o,
    output logic [DataBits-1:0] out_r_o,
    output logic [IterBits-1:0] out_iter_o,
    output logic                out_last_o,
    output logic                out_aborted_o,
    output logic                busy_o
);

    // Latency counter counts SqLatency-1 down to 0; keep it at least 1 bit.
    localparam int LatBits = (SqLatency > 1) ? $clog2(SqLatency) : 1;
    // Divisor used only when checkpoints are enabled; never zero.
    localparam int CkptDiv = (CheckpointInterval == 0) ? 1 : CheckpointInterval;
    localparam logic [LatBits-1:0]  LatLoad  = LatBits'(SqLatency - 1);
    localparam logic [IterBits-1:0] CkptDivV = IterBits'(CkptDiv);

    msu_seq_state_e      state_q, state_d;
    logic [DataBits-1:0] fb_nr_q, fb_nr_d;
    logic [DataBits-1:0] fb_r_q, fb_r_d;
    logic [IterBits-1:0] target_q, target_d;
    logic [IterBits-1:0] cnt_q, cnt_d;
    logic [LatBits-1:0]  lat_cnt_q, lat_cnt_d;
    logic                stop_pend_q, stop_pend_d;
    logic                last_q, last_d;
    logic                aborted_q, aborted_d;

    logic [IterBits-1:0] cnt_inc;
    logic                stop_seen;
    logic                ckpt_hit;

    // State and datapath registers; reset discards any job in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            fb_nr_q     <= '0;
            fb_r_q      <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            lat_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            last_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fb_nr_q     <= fb_nr_d;
            fb_r_q      <= fb_r_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            stop_pend_q <= stop_pend_d;
            last_q      <= last_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next-state and register update logic for job load, iteration and beats.
    always_comb begin
        state_d     = state_q;
        fb_nr_d     = fb_nr_q;
        fb_r_d      = fb_r_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        lat_cnt_d   = lat_cnt_q;
        last_d      = last_q;
        aborted_d   = aborted_q;
        cnt_inc     = cnt_q + IterBits'(1);
        // A stop in the completing cycle itself also counts at that completion.
        stop_seen   = stop_pend_q | stop_i;
        ckpt_hit    = (CheckpointInterval != 0) && ((cnt_inc % CkptDivV) == '0);
        // Stop is sticky from any non-IDLE cycle until the job ends.
        stop_pend_d = stop_pend_q | ((state_q != IDLE) & stop_i);

        unique case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (in_valid_i) begin
                    fb_nr_d   = in_nr_i;
                    fb_r_d    = in_r_i;
                    target_d  = in_iter_i;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    if (in_iter_i == '0) begin
                        // Nothing to compute: echo the input as the final beat.
                        last_d  = 1'b1;
                        state_d = EMIT;
                    end else begin
                        last_d  = 1'b0;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                lat_cnt_d = LatLoad;
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    fb_nr_d = dp_nr_i;
                    fb_r_d  = dp_r_i;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == target_q) begin
                        // Natural completion wins over a coincident stop.
                        last_d    = 1'b1;
                        aborted_d = 1'b0;
                        state_d   = EMIT;
                    end else if (stop_seen) begin
                        last_d    = 1'b1;
                        aborted_d = 1'b1;
                        state_d   = EMIT;
                    end else if (ckpt_hit) begin
                        last_d    = 1'b0;
                        aborted_d = 1'b0;
                        state_d   = EMIT;
                    end else begin
                        state_d   = LAUNCH;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LatBits'(1);
                end
            end
            EMIT: begin
                if (out_ready_i) begin
                    state_d = last_q ? IDLE : LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state and flags.
    always_comb begin
        in_ready_o    = (state_q == IDLE);
        busy_o        = (state_q != IDLE);
        dp_start_o    = (state_q == LAUNCH);
        dp_nr_o       = fb_nr_q;
        dp_r_o        = fb_r_q;
        out_valid_o   = (state_q == EMIT);
        out_nr_o      = fb_nr_q;
        out_r_o       = fb_r_q;
        out_iter_o    = cnt_q;
        out_last_o    = (state_q == EMIT) & last_q;
        out_aborted_o = (state_q == EMIT) & aborted_q;
    end

endmodule

// File: tb/tb_msu_seq.sv
// Self-checking bench for msu_seq with a behavioural squaring datapath
// ((nr+r)^2 mod 251, r returned as 0) and a queue-based scoreboard.
module tb_msu_seq;
  import msu_pkg::*;

  localparam int DW  = TotalWordBits;
  localparam int IW  = 32;
  localparam int LAT = 4;
  localparam int CI  = 2;

  typedef struct {
    logic [DW-1:0] nr;
    logic [DW-1:0] r;
    logic [IW-1:0] iter;
    logic          last;
    logic          aborted;
    int            cyc;     // expected first-valid cycle, -1 = not checked
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_nr_i = '0;
  logic [DW-1:0] in_r_i = '0;
  logic [IW-1:0] in_iter_i = '0;
  logic          stop_i = 1'b0;
  logic          dp_start_o;
  logic [DW-1:0] dp_nr_o, dp_r_o;
  logic [DW-1:0] dp_nr_i, dp_r_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] out_nr_o, out_r_o;
  logic [IW-1:0] out_iter_o;
  logic          out_last_o, out_aborted_o, busy_o;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    ready_rand = 1'b0;
  beat_t exp_q[$];

  msu_seq #(
    .DataBits(DW), .IterBits(IW), .SqLatency(LAT), .CheckpointInterval(CI)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_nr_i(in_nr_i), .in_r_i(in_r_i), .in_iter_i(in_iter_i),
    .stop_i(stop_i),
    .dp_start_o(dp_start_o), .dp_nr_o(dp_nr_o), .dp_r_o(dp_r_o),
    .dp_nr_i(dp_nr_i), .dp_r_i(dp_r_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_nr_o(out_nr_o), .out_r_o(out_r_o), .out_iter_o(out_iter_o),
    .out_last_o(out_last_o), .out_aborted_o(out_aborted_o),
    .busy_o(busy_o)
  );

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- datapath model ----------------
  function automatic logic [DW-1:0] sq(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = longint'(a) + longint'(b);
    return DW'((s * s) % 251);
  endfunction

  logic [DW-1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk_i) begin
    pipe[0] <= sq(dp_nr_o, dp_r_o);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_nr_i = pipe[LAT-1];
  assign dp_r_i  = '0;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_exp(input logic [DW-1:0] nr, input logic [DW-1:0] r,
                          input int it, input bit last, input bit ab, input int c);
    beat_t b;
    b.nr = nr; b.r = r; b.iter = IW'(it); b.last = last; b.aborted = ab; b.cyc = c;
    exp_q.push_back(b);
  endtask

  // Beats of an unaborted job; with ready held high every beat costs one
  // extra cycle on top of (LAT+1) cycles per iteration.
  task automatic model_job(input logic [DW-1:0] nr, input logic [DW-1:0] r,
                           input int it, input int h, input bit timed);
    logic [DW-1:0] vn, vr;
    int nb;
    if (it == 0) begin
      push_exp(nr, r, 0, 1'b1, 1'b0, timed ? h + 1 : -1);
      return;
    end
    vn = nr; vr = r; nb = 0;
    for (int k = 1; k <= it; k++) begin
      vn = sq(vn, vr);
      vr = '0;
      if (k == it || (CI != 0 && k % CI == 0)) begin
        nb++;
        push_exp(vn, vr, k, k == it, 1'b0, timed ? h + (LAT + 1) * k + nb : -1);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          launch_cnt = 0;
  int          last_launch = -1;
  bit          in_beat = 1'b0;
  int          beat_start = 0;
  logic [95:0] held_v;

  always @(negedge clk_i) begin
    logic [95:0] cur_v;
    beat_t e;
    cur_v = {30'd0, out_nr_o, out_r_o, out_iter_o, out_last_o, out_aborted_o};
    if (!rst_ni) begin
      launch_cnt = 0;
      last_launch = -1;
      in_beat = 1'b0;
    end else begin
      if (dp_start_o) begin
        if (last_launch >= 0)
          check("launch_gap_ok", 96'(cyc - last_launch >= LAT + 1), 96'd1);
        last_launch = cyc;
        launch_cnt++;
      end
      if (out_valid_o) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          beat_start = cyc;
          held_v = cur_v;
        end else begin
          check("stall_stable", cur_v, held_v);
        end
        if (out_ready_i) begin
          in_beat = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got nr=%0h iter=%0d, expected no beat", out_nr_o, out_iter_o);
          end else begin
            e = exp_q.pop_front();
            check("beat_nr", 96'(out_nr_o), 96'(e.nr));
            check("beat_r", 96'(out_r_o), 96'(e.r));
            check("beat_iter", 96'(out_iter_o), 96'(e.iter));
            check("beat_last", 96'(out_last_o), 96'(e.last));
            check("beat_aborted", 96'(out_aborted_o), 96'(e.aborted));
            if (e.cyc >= 0) check("beat_cycle", 96'(beat_start), 96'(e.cyc));
            if (e.last) begin
              check("launch_count", 96'(launch_cnt), 96'(e.iter));
              launch_cnt = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- random backpressure ----------------
  initial forever begin
    @(posedge clk_i); #1;
    if (ready_rand) out_ready_i = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks (enter/leave 1 time unit after posedge) ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic start_job(input logic [DW-1:0] nr, input logic [DW-1:0] r, input int it,
                           input int mode, output int h);
    int g;
    g = 0;
    while (!in_ready_o && g < 3000) begin step(1); g++; end
    check("in_ready_before_job", 96'(in_ready_o), 96'd1);
    h = cyc;
    if (mode > 0) model_job(nr, r, it, h, mode == 2);
    in_valid_i = 1'b1; in_nr_i = nr; in_r_i = r; in_iter_i = IW'(it);
    step(1);
    in_valid_i = 1'b0; in_nr_i = DW'($urandom); in_r_i = DW'($urandom);
    in_iter_i = IW'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !in_ready_o) && g < 5000) begin step(1); g++; end
    check("job_drained", 96'(exp_q.size() == 0 && in_ready_o), 96'd1);
    exp_q.delete();
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!out_valid_o && g < 200) begin step(1); g++; end
    check("beat_arrived", 96'(out_valid_o), 96'd1);
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1; step(1); stop_i = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 96'(in_ready_o), 96'd1);
    check("rst_out_valid", 96'(out_valid_o), 96'd0);
    check("rst_busy", 96'(busy_o), 96'd0);
    check("rst_dp_start", 96'(dp_start_o), 96'd0);
    check("rst_dp_ops", 96'({dp_nr_o, dp_r_o}), 96'd0);
    check("rst_out_fields", 96'({out_nr_o, out_r_o, out_iter_o, out_last_o, out_aborted_o}), 96'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int h;
    // reset
    step(3);
    check_reset_outputs();
    rst_ni = 1'b1;
    step(2);

    // single iteration, exact timing
    start_job(16'd3, 16'd0, 1, 0, h);
    push_exp(16'd9, 16'd0, 1, 1'b1, 1'b0, h + 6);
    wait_idle();

    // checkpoints every 2 iterations, constants from hand computation
    start_job(16'd3, 16'd0, 5, 0, h);
    push_exp(16'd81, 16'd0, 2, 1'b0, 1'b0, h + 11);
    push_exp(16'd221, 16'd0, 4, 1'b0, 1'b0, h + 22);
    push_exp(16'd147, 16'd0, 5, 1'b1, 1'b0, h + 28);
    wait_idle();

    // backpressure on first checkpoint beat
    out_ready_i = 1'b0;
    push_exp(16'd81, 16'd0, 2, 1'b0, 1'b0, -1);
    push_exp(16'd221, 16'd0, 4, 1'b0, 1'b0, -1);
    push_exp(16'd147, 16'd0, 5, 1'b1, 1'b0, -1);
    start_job(16'd3, 16'd0, 5, 0, h);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("stall_no_launch", 96'(dp_start_o), 96'd0);
      step(1);
    end
    out_ready_i = 1'b1;
    wait_idle();

    // zero iterations echoes the input, including r
    start_job(16'd7, 16'd5, 0, 0, h);
    push_exp(16'd7, 16'd5, 0, 1'b1, 1'b0, h + 1);
    wait_idle();

    // abort with a stop pulse mid-iteration
    start_job(16'd3, 16'd0, 1000, 0, h);
    push_exp(16'd81, 16'd0, 2, 1'b1, 1'b1, h + 11);
    wait_cyc(h + 8);
    pulse_stop();
    wait_cyc(h + 12);
    check("in_ready_after_abort", 96'(in_ready_o), 96'd1);
    wait_idle();

    // stop raised while a checkpoint beat is stalled: one more iteration
    out_ready_i = 1'b0;
    push_exp(16'd81, 16'd0, 2, 1'b0, 1'b0, -1);
    push_exp(16'd35, 16'd0, 3, 1'b1, 1'b1, -1);
    start_job(16'd3, 16'd0, 100, 0, h);
    wait_valid();
    pulse_stop();
    step(2);
    out_ready_i = 1'b1;
    wait_idle();

    // stop coinciding with natural completion is not an abort
    start_job(16'd3, 16'd0, 1, 0, h);
    push_exp(16'd9, 16'd0, 1, 1'b1, 1'b0, h + 6);
    wait_cyc(h + 3);
    pulse_stop();
    wait_idle();

    // stop in IDLE together with a new job is ignored
    stop_i = 1'b1;
    start_job(16'd3, 16'd0, 1, 2, h);
    stop_i = 1'b0;
    wait_idle();

    // reset during WAIT discards the job
    start_job(16'd3, 16'd0, 1000, 0, h);
    wait_cyc(h + 3);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    step(3);
    rst_ni = 1'b1;
    step(1);
    start_job(16'd3, 16'd0, 3, 0, h);
    push_exp(16'd81, 16'd0, 2, 1'b0, 1'b0, h + 11);
    push_exp(16'd35, 16'd0, 3, 1'b1, 1'b0, h + 17);
    wait_idle();

    // randomized jobs, timed with ready held high
    for (int j = 0; j < 8; j++) begin
      start_job(DW'($urandom), DW'($urandom_range(0, 255)), $urandom_range(0, 7), 2, h);
      wait_idle();
    end

    // randomized jobs under random backpressure
    ready_rand = 1'b1;
    for (int j = 0; j < 20; j++) begin
      start_job(DW'($urandom), DW'($urandom_range(0, 255)), $urandom_range(0, 9), 1, h);
      wait_idle();
    end
    ready_rand = 1'b0;
    step(2);
    out_ready_i = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
